// File: rtl/pwm_bank_pkg.sv
// Shared constants and types for the PWM bank.
package pwm_pkg;

  localparam int unsigned PwmWidth = 8;
  localparam int unsigned PwmNch   = 4;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_bank_if.sv
// Shadow duty write bus shared by the PWM bank and whatever programs it.
interface pwm_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
);

  localparam int unsigned ChW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             duty_wr;
  logic [ChW-1:0]   duty_ch;
  logic [WIDTH-1:0] duty_data;

  modport master (output duty_wr, output duty_ch, output duty_data);
  modport slave  (input duty_wr, input duty_ch, input duty_data);

endinterface

// File: rtl/pwm_bank_chan.sv
// One PWM channel: shadow/active duty pair, pending flag and registered compare output.
module pwm_chan #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             xfer,
  input  logic [WIDTH-1:0] cnt,
  input  logic             wr,
  input  logic [WIDTH-1:0] data,
  output logic             pwm,
  output logic             pending
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] duty_act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      duty_act_q <= '0;
      pending    <= 1'b0;
      pwm        <= 1'b0;
    end else begin
      // A write in the transfer cycle lands after the old shadow has been taken.
      if (xfer && pending) duty_act_q <= shadow_q;
      if (wr) shadow_q <= data;
      if (wr) begin
        pending <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
      pwm <= en && (cnt < duty_act_q);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM with a shared counter; optional center-aligned mode under PWM_CENTER_EN.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PwmWidth,
  parameter int unsigned NCH   = PwmNch
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             center,
  input  logic [WIDTH-1:0] period,
  pwm_bank_if.slave        bus,
  output logic [NCH-1:0]   pwm_sig,
  output logic [NCH-1:0]   pending,
  output logic             period_strobe
);

  localparam int unsigned ChW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_act_q;
  logic             boundary;
  logic             xfer;

`ifdef PWM_CENTER_EN
  pwm_mode_e mode_act_q;
  logic      dir_down_q, dir_down_d;
`else
  logic      unused_center;
  assign unused_center = center;
`endif

  always_comb begin
    boundary = 1'b0;
    cnt_d    = cnt_q + One;
`ifdef PWM_CENTER_EN
    dir_down_d = dir_down_q;
    if (mode_act_q == PWM_CENTER) begin
      if (dir_down_q) begin
        cnt_d    = cnt_q - One;
        boundary = (cnt_q == One);
      end else if (cnt_q == per_act_q) begin
        // With a top of 0 or 1 there is no down leg; the peak is the boundary.
        if (per_act_q <= One) begin
          boundary = 1'b1;
        end else begin
          cnt_d      = per_act_q - One;
          dir_down_d = 1'b1;
        end
      end
    end else begin
      boundary = (cnt_q == per_act_q);
    end
`else
    boundary = (cnt_q == per_act_q);
`endif
    xfer = boundary || !en;
    if (xfer) begin
      cnt_d = '0;
`ifdef PWM_CENTER_EN
      dir_down_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      per_act_q     <= '1;
      period_strobe <= 1'b0;
`ifdef PWM_CENTER_EN
      mode_act_q    <= PWM_EDGE;
      dir_down_q    <= 1'b0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      period_strobe <= en && boundary;
      if (xfer) per_act_q <= period;
`ifdef PWM_CENTER_EN
      if (xfer) mode_act_q <= pwm_mode_e'(center);
      dir_down_q <= dir_down_d;
`endif
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    pwm_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .xfer   (xfer),
      .cnt    (cnt_q),
      .wr     (bus.duty_wr && (bus.duty_ch == ChW'(i))),
      .data   (bus.duty_data),
      .pwm    (pwm_sig[i]),
      .pending(pending[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank with a queue of expected per-window measurements.
module tb_pwm_bank;
  import pwm_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         center = 1'b0;
  logic [W-1:0] period = '0;
  logic [N-1:0] pwm_sig;
  logic [N-1:0] pending;
  logic         period_strobe;

  pwm_bank_if #(.WIDTH(W), .NCH(N)) bus ();

  pwm_bank #(
    .WIDTH(W),
    .NCH  (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .center       (center),
    .period       (period),
    .bus          (bus),
    .pwm_sig      (pwm_sig),
    .pending      (pending),
    .period_strobe(period_strobe)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int hi[N];
  int strobes;
  int strobe_at;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input int obs);
    int e;
    e = exp_q.pop_front();
    chk(tag, obs, e);
  endtask

  // Samples n negedges, counting high cycles per channel and strobes.
  task automatic measure(input int n);
    for (int c = 0; c < N; c++) hi[c] = 0;
    strobes   = 0;
    strobe_at = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) if (pwm_sig[c]) hi[c]++;
      if (period_strobe) begin
        strobes++;
        strobe_at = k;
      end
    end
  endtask

  task automatic wait_strobe(input string tag, input int max_cyc);
    int seen;
    seen = 0;
    for (int k = 0; k < max_cyc && seen == 0; k++) begin
      @(negedge clk);
      if (period_strobe) seen = 1;
    end
    chk(tag, seen, 1);
  endtask

  task automatic write(input int ch, input int data);
    bus.duty_wr   = 1'b1;
    bus.duty_ch   = 2'(ch);
    bus.duty_data = W'(data);
    @(negedge clk);
    bus.duty_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.duty_wr   = 1'b0;
    bus.duty_ch   = '0;
    bus.duty_data = '0;

    // Reset state
    #12;
    chk("rst_pwm", int'(pwm_sig), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_strobe", int'(period_strobe), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full 8-bit period, ch0 = 64 applied at the first boundary
    period = 8'd255;
    en     = 1'b1;
    @(negedge clk);
    write(0, 64);
    chk("t1_pending_set", int'(pending[0]), 1);
    wait_strobe("t1_first_bnd", 300);
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(64);
      exp_q.push_back(1);
      measure(256);
      chk_pop("t1_hi0", hi[0]);
      chk_pop("t1_strobes", strobes);
    end
    chk("t1_pending_clr", int'(pending[0]), 0);

    // Duty 0 and duty > period saturate
    write(1, 0);
    write(2, 100);
    write(3, 200);
    period = 8'd99;
    wait_strobe("t2_bnd", 300);
    exp_q.push_back(64);
    exp_q.push_back(0);
    exp_q.push_back(100);
    exp_q.push_back(100);
    exp_q.push_back(1);
    measure(100);
    chk_pop("t2_hi0", hi[0]);
    chk_pop("t2_hi1", hi[1]);
    chk_pop("t2_hi2", hi[2]);
    chk_pop("t2_hi3", hi[3]);
    chk_pop("t2_strobes", strobes);
    chk("t2_pending", int'(pending), 0);

    // Write landing in the boundary cycle: old shadow transfers, new one stays pending
    write(0, 50);
    chk("t3_pending_50", int'(pending[0]), 1);
    repeat (98) @(negedge clk);
    write(0, 32);
    chk("t3_bnd_strobe", int'(period_strobe), 1);
    chk("t3_pending_kept", int'(pending[0]), 1);
    exp_q.push_back(50);
    measure(100);
    chk_pop("t3_hi0_old", hi[0]);
    chk("t3_pending_clr", int'(pending[0]), 0);
    exp_q.push_back(32);
    measure(100);
    chk_pop("t3_hi0_new", hi[0]);

    // Asynchronous reset in the high phase with a pending write
    write(1, 7);
    chk("t4_pending1", int'(pending[1]), 1);
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      @(negedge clk);
      if (pwm_sig[0]) seen = 1;
    end
    chk("t4_high_seen", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_pwm", int'(pwm_sig), 0);
    chk("t4_rst_pending", int'(pending), 0);
    chk("t4_rst_strobe", int'(period_strobe), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Disabled: pending write applies immediately, outputs idle
    en = 1'b0;
    write(0, 20);
    chk("t5_pending_set", int'(pending[0]), 1);
    @(negedge clk);
    chk("t5_pending_applied", int'(pending[0]), 0);
    chk("t5_pwm_idle", int'(pwm_sig), 0);
    period = 8'd9;
    @(negedge clk);
    en = 1'b1;
    exp_q.push_back(10);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(10);
    measure(10);
    chk_pop("t5_hi0", hi[0]);
    chk_pop("t5_hi1", hi[1]);
    chk_pop("t5_strobes", strobes);
    chk_pop("t5_strobe_at", strobe_at);

    // Period 0: every cycle is a boundary
    period = 8'd0;
    wait_strobe("t6_bnd", 20);
    exp_q.push_back(10);
    exp_q.push_back(10);
    measure(10);
    chk_pop("t6_strobes", strobes);
    chk_pop("t6_hi0", hi[0]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_strobe", int'(period_strobe), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode request: center-aligned when built in, otherwise ignored
    en     = 1'b0;
    center = 1'b1;
    period = 8'd10;
    write(0, 4);
    @(negedge clk);
    en = 1'b1;
`ifdef PWM_CENTER_EN
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(7);
      exp_q.push_back(1);
      exp_q.push_back(20);
      measure(20);
      chk_pop("t7_center_hi0", hi[0]);
      chk_pop("t7_center_strobes", strobes);
      chk_pop("t7_center_strobe_at", strobe_at);
    end
`else
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(4);
      exp_q.push_back(1);
      exp_q.push_back(11);
      measure(11);
      chk_pop("t7_edge_hi0", hi[0]);
      chk_pop("t7_edge_strobes", strobes);
      chk_pop("t7_edge_strobe_at", strobe_at);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter WIDTH, default 8, counter/duty/period bit width.
REQ-002 Parameter NCH, default 4, number of PWM channels.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  run enable; low forces idle.
REQ-006 center  input  1  mode request, 1 = center-aligned; sampled only at period boundary.
REQ-007 period  input  WIDTH  counter top value; sampled only at period boundary.
REQ-008 duty_wr  input  1  one-cycle write strobe for a shadow duty register.
REQ-009 duty_ch  input  max(1,$clog2(NCH))  channel index for duty_wr.
REQ-010 duty_data  input  WIDTH  duty value to write.
REQ-011 pwm_sig  output  NCH  registered PWM outputs.
REQ-012 pending  output  NCH  per-channel flag: shadow written, not yet applied.
REQ-013 period_strobe  output  1  one-cycle pulse, registered, marking each period boundary.

Function
REQ-014 Active period (per_act), active mode (mode_act) and per-channel active duty (duty_act[i]) SHALL change only at a period boundary or while en=0.
REQ-015 Edge mode: cnt counts 0..per_act; cnt==per_act is the boundary, next cnt=0; period length per_act+1 cycles.
REQ-016 pwm_sig[i] SHALL be registered (cnt < duty_act[i]), one cycle behind cnt; duty 0 = always low, duty > per_act = always high.
REQ-017 At a boundary: duty_act[i] <= shadow[i] for every pending channel, pending cleared, per_act <= period, mode_act <= center, period_strobe asserted the next cycle.
REQ-018 duty_wr with duty_ch < NCH writes shadow and sets pending; duty_ch >= NCH ignored.
REQ-019 duty_wr in the boundary cycle: transfer uses the old shadow; new value stored, pending stays 1 until next boundary.
REQ-020 per_act=0: cnt stays 0, every cycle a boundary, period_strobe held high.
REQ-021 en=0: cnt<=0, direction up, pwm_sig<=0, period_strobe<=0, pending shadows/period/mode transferred each cycle; on en rising, period starts at cnt=0.

Reset
REQ-022 rst_n low SHALL immediately force cnt=0, direction up, pwm_sig=0, pending=0, period_strobe=0, shadow and duty_act=0, per_act=all ones, mode_act=edge.
REQ-023 Reset mid-period SHALL abort the period; no partial transfer occurs.

Configuration
REQ-024 Macro PWM_CENTER_EN defined: mode_act=1 counts up 0..per_act then down per_act-1..1, period 2*per_act cycles, boundary at cnt==1 while down (next cnt=0, up); high cycles per period 2*duty-1 for 1<=duty<=per_act.
REQ-025 Macro undefined: center port present but ignored, mode_act fixed edge, no direction logic synthesised.

Structure
REQ-026 Package pwm_pkg SHALL hold default WIDTH/NCH constants and mode typedef (PWM_EDGE, PWM_CENTER).
REQ-027 Sub-module pwm_chan (shadow, pending, duty_act, compare, output flop) SHALL be instantiated NCH times by generate; counter/boundary logic stays in pwm_bank.

Verification (WIDTH=8, NCH=4)
REQ-028 Reset, en=1, period=255, write ch0=64 -> after first boundary pwm_sig[0] high 64 / low 192 per 256 cycles; period_strobe every 256 cycles.
REQ-029 period=99, ch1=0, ch2=100, ch3=200 -> ch1 constant 0, ch2 and ch3 constant 1.
REQ-030 duty_wr ch0=32 exactly in boundary cycle -> old shadow applied, pending[0]=1, 32 applied one period later.
REQ-031 PWM_CENTER_EN, center=1, period=10, ch0=4 -> period 20 cycles, pwm_sig[0] high 7 cycles centred on cnt=0.
REQ-032 rst_n low mid-high-phase -> pwm_sig, pending, period_strobe 0 without clock edge; en=0 with pending write -> applied, pwm_sig 0, cnt 0.
